// File: rtl/hero_bus_rx_if.sv
// Hero write bus plus local consumer port, bundled for hero_bus_rx.
// Optional macro HERO_BUS_RX_PARITY_EN adds the hero_parity signal.
interface hero_bus_rx_if #(
  parameter int unsigned HERO_WIDTH = 32,
  parameter int unsigned MAX_BEATS  = 5
);
  localparam int unsigned IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  logic [1:0]            hero_cycle_type;
  logic [HERO_WIDTH-1:0] hero_data;
`ifdef HERO_BUS_RX_PARITY_EN
  logic                  hero_parity;
`endif
  logic [1:0]            hero_credit_return;
  logic                  out_valid;
  logic                  out_ready;
  logic [HERO_WIDTH-1:0] out_data;
  logic                  out_last;
  logic [IDX_W-1:0]      out_beat_idx;
  logic                  err_valid;
  logic [2:0]            err_code;

`ifdef HERO_BUS_RX_PARITY_EN
  modport master (
    output hero_cycle_type, hero_data, hero_parity, out_ready,
    input  hero_credit_return, out_valid, out_data, out_last, out_beat_idx,
           err_valid, err_code
  );
  modport slave (
    input  hero_cycle_type, hero_data, hero_parity, out_ready,
    output hero_credit_return, out_valid, out_data, out_last, out_beat_idx,
           err_valid, err_code
  );
`else
  modport master (
    output hero_cycle_type, hero_data, out_ready,
    input  hero_credit_return, out_valid, out_data, out_last, out_beat_idx,
           err_valid, err_code
  );
  modport slave (
    input  hero_cycle_type, hero_data, out_ready,
    output hero_credit_return, out_valid, out_data, out_last, out_beat_idx,
           err_valid, err_code
  );
`endif
endinterface

// File: rtl/hero_bus_rx.sv
// Hero bus receiver: frames VALID/DONE traffic into packets, buffers beats
// in a FIFO with a registered head, and returns credits to the transmitter.
// Optional macro HERO_BUS_RX_PARITY_EN enables odd-parity checking of beats.
module hero_bus_rx #(
  parameter int unsigned HERO_WIDTH = 32,
  parameter int unsigned MAX_BEATS  = 5,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  hero_bus_rx_if.slave bus
);
  localparam int unsigned IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IN_PKT = 2'd1,
    ST_DROP   = 2'd2
  } state_t;

  typedef struct packed {
    logic                  last;
    logic [IDX_W-1:0]      idx;
    logic [HERO_WIDTH-1:0] data;
  } beat_t;

  state_t                r_state, w_state_nxt;
  logic [HERO_WIDTH-1:0] r_stg_data;
  logic [IDX_W-1:0]      r_stg_idx, w_load_idx;
  beat_t                 r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [CNT_W-1:0]      r_count, w_count_nxt, w_remain;
  beat_t                 r_head, w_head_nxt, w_push_beat;
  logic                  r_out_valid;
  logic [1:0]            r_credit, w_credit_nxt;
  logic                  r_err_valid;
  logic [2:0]            r_err_code, w_err_code;

  logic w_is_valid, w_is_done, w_is_rsvd, w_par_bad, w_beat;
  logic w_load, w_push, w_drop, w_err_empty, w_err_long;
  logic w_pop, w_push_ok, w_err_full, w_err_any;

  // Cycle-type decode; reserved type behaves like IDLE apart from its error.
  assign w_is_valid = (bus.hero_cycle_type == 2'd1);
  assign w_is_done  = (bus.hero_cycle_type == 2'd2);
  assign w_is_rsvd  = (bus.hero_cycle_type == 2'd3);

`ifdef HERO_BUS_RX_PARITY_EN
  assign w_par_bad = w_is_valid && !(^{bus.hero_data, bus.hero_parity});
`else
  assign w_par_bad = 1'b0;
`endif

  // A parity-failed beat is invisible to the framing logic.
  assign w_beat = w_is_valid && !w_par_bad;

  // Packet framing: next state, stage loads, FIFO pushes and drops.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_idx  = '0;
    w_push      = 1'b0;
    w_push_beat = '0;
    w_drop      = 1'b0;
    w_err_empty = 1'b0;
    w_err_long  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_beat) begin
          w_load      = 1'b1;
          w_state_nxt = ST_IN_PKT;
        end else if (w_is_done) begin
          w_err_empty = 1'b1;
        end
      end
      ST_IN_PKT: begin
        if (w_beat) begin
          w_push           = 1'b1;
          w_push_beat.data = r_stg_data;
          w_push_beat.idx  = r_stg_idx;
          if (r_stg_idx == IDX_W'(MAX_BEATS - 1)) begin
            w_push_beat.last = 1'b1;
            w_drop           = 1'b1;
            w_err_long       = 1'b1;
            w_state_nxt      = ST_DROP;
          end else begin
            w_load     = 1'b1;
            w_load_idx = r_stg_idx + IDX_W'(1);
          end
        end else if (w_is_done) begin
          w_push           = 1'b1;
          w_push_beat.data = r_stg_data;
          w_push_beat.idx  = r_stg_idx;
          w_push_beat.last = 1'b1;
          w_state_nxt      = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (w_beat) begin
          w_drop = 1'b1;
        end else if (w_is_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FIFO bookkeeping; a push into a full FIFO is allowed only alongside a pop.
  assign w_pop       = r_out_valid && bus.out_ready;
  assign w_push_ok   = w_push && ((r_count < CNT_W'(FIFO_DEPTH)) || w_pop);
  assign w_err_full  = w_push && !w_push_ok;
  assign w_count_nxt = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
  assign w_rd_nxt    = r_rd_ptr + PTR_W'(w_pop);
  assign w_remain    = r_count - CNT_W'(w_pop);
  assign w_head_nxt  = (w_remain == '0) ? w_push_beat : r_mem[w_rd_nxt];

  assign w_credit_nxt = 2'(w_pop) + 2'(w_drop || w_par_bad);

  // Error priority: lowest code wins.
  always_comb begin
    w_err_code = 3'd0;
    if (w_err_empty)     w_err_code = 3'd1;
    else if (w_err_long) w_err_code = 3'd2;
    else if (w_is_rsvd)  w_err_code = 3'd3;
    else if (w_err_full) w_err_code = 3'd4;
    else if (w_par_bad)  w_err_code = 3'd5;
  end
  assign w_err_any = (w_err_code != 3'd0);

  // FSM state and staged beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_stg_data <= '0;
      r_stg_idx  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_stg_data <= bus.hero_data;
        r_stg_idx  <= w_load_idx;
      end
    end
  end

  // Beat storage; contents are qualified by the count so need no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_push_beat;
  end

  // FIFO pointers, count and the registered head presented to the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_head      <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_rd_ptr    <= w_rd_nxt;
      r_count     <= w_count_nxt;
      r_out_valid <= (w_count_nxt != '0);
      r_head      <= w_head_nxt;
    end
  end

  // Credit return and error reporting; err_code holds until the next error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit    <= 2'd0;
      r_err_valid <= 1'b0;
      r_err_code  <= 3'd0;
    end else begin
      r_credit    <= w_credit_nxt;
      r_err_valid <= w_err_any;
      if (w_err_any) r_err_code <= w_err_code;
    end
  end

  assign bus.hero_credit_return = r_credit;
  assign bus.out_valid          = r_out_valid;
  assign bus.out_data           = r_head.data;
  assign bus.out_last           = r_head.last;
  assign bus.out_beat_idx       = r_head.idx;
  assign bus.err_valid          = r_err_valid;
  assign bus.err_code           = r_err_code;
endmodule

// File: tb/tb_hero_bus_rx.sv
// Self-checking bench for hero_bus_rx: reset, vector table, directed
// multi-cycle scenarios, and randomized traffic against a queue-based model.
module tb_hero_bus_rx;
  localparam int unsigned HW = 32;
  localparam int unsigned MB = 5;
  localparam int unsigned FD = 8;
  localparam logic [1:0] T_IDLE = 2'd0, T_VALID = 2'd1, T_DONE = 2'd2, T_RSVD = 2'd3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hero_bus_rx_if #(.HERO_WIDTH(HW), .MAX_BEATS(MB)) bus ();
  hero_bus_rx #(.HERO_WIDTH(HW), .MAX_BEATS(MB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [HW-1:0] data;
    logic          last;
    int            idx;
  } beat_t;

  typedef struct {
    logic [1:0]    t;
    logic [HW-1:0] d;
    logic          rdy;
    logic          ev;
    logic [HW-1:0] ed;
    logic          el;
    int            ei;
    int            ec;
    logic          eev;
    int            ecode;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: packet rules applied to a plain queue of expected beats.
  beat_t         m_q[$];
  int            m_cnt;
  logic [HW-1:0] m_staged;
  bit            m_dropping;
  int            m_credit, m_errv, m_code;

  // Observation of the DUT across directed scenarios.
  beat_t cap_q[$];
  int    err_log[$];
  int    cred_sum;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_cnt = 0; m_staged = '0; m_dropping = 1'b0;
    m_credit = 0; m_errv = 0; m_code = 0;
  endfunction

  function automatic void model_step(input logic [1:0] t, input logic [HW-1:0] d, input logic rdy);
    int    err, drop;
    bit    pop, push;
    beat_t pb;
    err = 0; drop = 0; push = 1'b0; pb = '{default: '0};
    pop = (m_q.size() > 0) && rdy;
    if (t == T_RSVD) begin
      err = 3;
    end else if (t == T_VALID) begin
      if (m_dropping) drop = 1;
      else if (m_cnt == 0) begin m_staged = d; m_cnt = 1; end
      else if (m_cnt == MB) begin
        pb = '{m_staged, 1'b1, m_cnt - 1}; push = 1'b1;
        drop = 1; err = 2; m_dropping = 1'b1; m_cnt = 0;
      end else begin
        pb = '{m_staged, 1'b0, m_cnt - 1}; push = 1'b1;
        m_staged = d; m_cnt++;
      end
    end else if (t == T_DONE) begin
      if (m_dropping) m_dropping = 1'b0;
      else if (m_cnt == 0) err = 1;
      else begin pb = '{m_staged, 1'b1, m_cnt - 1}; push = 1'b1; m_cnt = 0; end
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < FD) m_q.push_back(pb);
      else if (err == 0) err = 4;
    end
    m_credit = int'(pop) + drop;
    m_errv   = (err != 0);
    if (err != 0) m_code = err;
  endfunction

  // One clock cycle: drive, record any pop, advance the model, sample after the edge.
  task automatic cycle(input logic [1:0] t, input logic [HW-1:0] d, input logic rdy);
    bus.hero_cycle_type = t;
    bus.hero_data       = d;
`ifdef HERO_BUS_RX_PARITY_EN
    bus.hero_parity     = ~^d;
`endif
    bus.out_ready       = rdy;
    if (bus.out_valid && rdy)
      cap_q.push_back('{bus.out_data, bus.out_last, int'(bus.out_beat_idx)});
    model_step(t, d, rdy);
    @(posedge clk);
    #1;
    cred_sum += int'(bus.hero_credit_return);
    if (bus.err_valid) err_log.push_back(int'(bus.err_code));
  endtask

  task automatic check_model(input int cyc);
    check($sformatf("rnd%0d_valid", cyc), bus.out_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check($sformatf("rnd%0d_data", cyc), bus.out_data, m_q[0].data);
      check($sformatf("rnd%0d_last", cyc), bus.out_last, m_q[0].last);
      check($sformatf("rnd%0d_idx", cyc), bus.out_beat_idx, m_q[0].idx);
    end
    check($sformatf("rnd%0d_credit", cyc), bus.hero_credit_return, m_credit);
    check($sformatf("rnd%0d_errv", cyc), bus.err_valid, m_errv);
    check($sformatf("rnd%0d_code", cyc), bus.err_code, m_code);
  endtask

  task automatic clear_obs();
    cap_q.delete(); err_log.delete(); cred_sum = 0;
  endtask

  vec_t vec[15];

  initial begin
    bus.hero_cycle_type = T_IDLE;
    bus.hero_data       = '0;
`ifdef HERO_BUS_RX_PARITY_EN
    bus.hero_parity     = 1'b1;
`endif
    bus.out_ready       = 1'b0;
    model_reset();
    clear_obs();

    // Single-beat packet, gapped 3-beat packet, then empty DONE and reserved type.
    vec[0]  = '{T_VALID, 32'hA5, 1'b1, 1'b0, 32'h0,  1'b0, 0, 0, 1'b0, 0};
    vec[1]  = '{T_DONE,  32'h0,  1'b1, 1'b1, 32'hA5, 1'b1, 0, 0, 1'b0, 0};
    vec[2]  = '{T_IDLE,  32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 0, 1, 1'b0, 0};
    vec[3]  = '{T_IDLE,  32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 0, 0, 1'b0, 0};
    vec[4]  = '{T_VALID, 32'h1,  1'b1, 1'b0, 32'h0,  1'b0, 0, 0, 1'b0, 0};
    vec[5]  = '{T_IDLE,  32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 0, 0, 1'b0, 0};
    vec[6]  = '{T_IDLE,  32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 0, 0, 1'b0, 0};
    vec[7]  = '{T_VALID, 32'h2,  1'b1, 1'b1, 32'h1,  1'b0, 0, 0, 1'b0, 0};
    vec[8]  = '{T_VALID, 32'h3,  1'b1, 1'b1, 32'h2,  1'b0, 1, 1, 1'b0, 0};
    vec[9]  = '{T_DONE,  32'h0,  1'b1, 1'b1, 32'h3,  1'b1, 2, 1, 1'b0, 0};
    vec[10] = '{T_IDLE,  32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 0, 1, 1'b0, 0};
    vec[11] = '{T_IDLE,  32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 0, 0, 1'b0, 0};
    vec[12] = '{T_DONE,  32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 0, 0, 1'b1, 1};
    vec[13] = '{T_RSVD,  32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 0, 0, 1'b1, 3};
    vec[14] = '{T_IDLE,  32'h0,  1'b1, 1'b0, 32'h0,  1'b0, 0, 0, 1'b0, 3};

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid",  bus.out_valid, 0);
    check("rst_data",   bus.out_data, 0);
    check("rst_last",   bus.out_last, 0);
    check("rst_idx",    bus.out_beat_idx, 0);
    check("rst_credit", bus.hero_credit_return, 0);
    check("rst_errv",   bus.err_valid, 0);
    check("rst_code",   bus.err_code, 0);
    rst_n = 1'b1;

    // Vector table.
    for (int k = 0; k < 15; k++) begin
      cycle(vec[k].t, vec[k].d, vec[k].rdy);
      check($sformatf("vec%0d_valid", k), bus.out_valid, vec[k].ev);
      if (vec[k].ev) begin
        check($sformatf("vec%0d_data", k), bus.out_data, vec[k].ed);
        check($sformatf("vec%0d_last", k), bus.out_last, vec[k].el);
        check($sformatf("vec%0d_idx", k), bus.out_beat_idx, vec[k].ei);
      end
      check($sformatf("vec%0d_credit", k), bus.hero_credit_return, vec[k].ec);
      check($sformatf("vec%0d_errv", k), bus.err_valid, vec[k].eev);
      check($sformatf("vec%0d_code", k), bus.err_code, vec[k].ecode);
    end

    // Over-length packet: 7 VALIDs then DONE with the consumer stalled.
    clear_obs();
    for (int i = 0; i < 7; i++) cycle(T_VALID, 32'hB000_0000 + 32'(i), 1'b0);
    cycle(T_DONE, '0, 1'b0);
    check("olen_credits_in", cred_sum, 2);
    check("olen_err_cnt", err_log.size(), 1);
    if (err_log.size() > 0) check("olen_err_code", err_log[0], 2);
    for (int i = 0; i < 6; i++) cycle(T_IDLE, '0, 1'b1);
    check("olen_beats", cap_q.size(), 5);
    for (int i = 0; i < cap_q.size(); i++) begin
      check($sformatf("olen_data%0d", i), cap_q[i].data, 32'hB000_0000 + 32'(i));
      check($sformatf("olen_idx%0d", i), cap_q[i].idx, i);
      check($sformatf("olen_last%0d", i), cap_q[i].last, i == 4);
    end
    check("olen_credits_total", cred_sum, 7);

    // FIFO overflow: 9 single-beat packets into a stalled consumer.
    clear_obs();
    for (int p = 0; p < 9; p++) begin
      cycle(T_VALID, 32'h100 + 32'(p), 1'b0);
      cycle(T_DONE, '0, 1'b0);
    end
    check("full_credits_in", cred_sum, 0);
    check("full_err_cnt", err_log.size(), 1);
    if (err_log.size() > 0) check("full_err_code", err_log[0], 4);
    for (int i = 0; i < 10; i++) cycle(T_IDLE, '0, 1'b1);
    check("full_beats", cap_q.size(), 8);
    for (int i = 0; i < cap_q.size(); i++) begin
      check($sformatf("full_data%0d", i), cap_q[i].data, 32'h100 + 32'(i));
      check($sformatf("full_last%0d", i), cap_q[i].last, 1);
    end
    check("full_credits_total", cred_sum, 8);

    // Reset in the middle of a packet.
    clear_obs();
    cycle(T_VALID, 32'hC1, 1'b0);
    cycle(T_VALID, 32'hC2, 1'b0);
    check("mid_valid_before", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_data", bus.out_data, 0);
    check("mid_rst_credit", bus.hero_credit_return, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(T_VALID, 32'h77, 1'b1);
    cycle(T_DONE, '0, 1'b1);
    check("mid_new_valid", bus.out_valid, 1);
    check("mid_new_data", bus.out_data, 32'h77);
    check("mid_new_last", bus.out_last, 1);
    check("mid_new_idx", bus.out_beat_idx, 0);
    cycle(T_IDLE, '0, 1'b1);
    check("mid_new_credit", bus.hero_credit_return, 1);

    // Randomized traffic against the reference model.
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      int          r;
      logic [1:0]  t;
      r = int'($urandom_range(0, 99));
      t = (r < 30) ? T_IDLE : (r < 75) ? T_VALID : (r < 95) ? T_DONE : T_RSVD;
      cycle(t, HW'($urandom), $urandom_range(0, 9) < 7);
      check_model(i);
    end
    for (int i = 0; i < 12; i++) begin
      cycle(T_IDLE, '0, 1'b1);
      check_model(3000 + i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/hero_bus_rx.md
Name: hero_bus_rx

Overview:
- Receiving end of the hero write bus. Samples per-cycle hero traffic (cycle type IDLE/VALID/DONE plus a HERO_WIDTH data word) from a credit-based transmitter.
- Frames VALID beats into packets terminated by DONE and buffers the beats in a FIFO.
- Presents the beats to a local consumer over valid/ready with a last flag.
- Returns one credit to the transmitter per consumed or dropped beat.

Parameters:
- HERO_WIDTH, 32, data width of the hero bus.
- MAX_BEATS, 5, maximum VALID beats per packet.
- FIFO_DEPTH, 8, beat buffer entries; also the transmitter's initial credit count. Power of 2, ≥2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- hero_cycle_type  input  2  0=IDLE, 1=VALID, 2=DONE, 3=reserved.
- hero_data  input  HERO_WIDTH  beat data; meaningful only when VALID.
- hero_credit_return  output  2  credits returned this cycle (0..2).
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- out_data  output  HERO_WIDTH  head beat data.
- out_last  output  1  head is final beat of its packet.
- out_beat_idx  output  $clog2(MAX_BEATS)  beat index within packet, 0-based.
- err_valid  output  1  one-cycle error pulse.
- err_code  output  3  error cause; held until the next err_valid.

Behaviour:
- Interface is decided: one clock `clk`; reset `rst_n`, asynchronous, active-low.
- Reset values:
  - all outputs 0;
  - FIFO empty;
  - stage register empty;
  - FSM in IDLE;
  - beat counter 0.
- FSM states: IDLE, IN_PKT, DROP.
  - IDLE + VALID: load beat into stage, idx 0, go to IN_PKT.
  - IN_PKT + VALID: push the staged beat with last=0, load the new beat, idx+1.
  - IN_PKT + DONE: push the staged beat with last=1, go to IDLE.
  - IN_PKT + IDLE cycle: gap; stage held, no change.
- Single-beat packet timing: VALID in cycle 0, DONE in cycle 1 → out_valid high in cycle 2.
- Packet over-length:
  - a VALID arriving when the staged beat has idx MAX_BEATS-1 pushes the staged beat with last=1, drops the new beat, pulses err code 2, and goes to DROP;
  - DROP discards VALID beats until DONE, then goes to IDLE.
- DONE in IDLE (empty packet): err code 1, ignored, no credit.
- Reserved type 3 in any state: err code 3, treated as IDLE.
- FIFO push:
  - accepted if count < FIFO_DEPTH, or a pop occurs in the same cycle;
  - otherwise the beat is lost and err code 4 is raised (credit violation); no credit is returned for it.
- Pop: out_valid && out_ready. out_valid/out_data/out_last/out_beat_idx come from the registered FIFO head; no combinational path from input to output.
- Credits:
  - hero_credit_return is registered;
  - equals pops in cycle N plus beats dropped (DROP or over-length) in cycle N, driven in cycle N+1;
  - maximum value 2.
- Simultaneous errors in one cycle: the lowest code wins.
- Pointers wrap modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH)+1.
- Reset mid-packet: all state cleared immediately; no credits are returned for the lost beats. The transmitter resets in the same domain.

Optional Feature:
HERO_BUS_RX_PARITY_EN
- Defined:
  - adds input hero_parity (1 bit), odd parity over hero_data, checked on VALID only;
  - on mismatch the beat is dropped, err code 5 pulses, one credit is returned, and the FSM state is unchanged;
  - a packet whose every beat failed parity follows the empty-DONE rule (code 1).
- Undefined: no hero_parity port and no check.

Test Plan:
- VALID(0xA5) then DONE, out_ready=1 → out_valid in cycle 2 with data 0xA5, last=1, idx=0; hero_credit_return=1 in cycle 3.
- VALID 0x1, IDLE, IDLE, VALID 0x2, VALID 0x3, DONE → 3 beats out, idx 0,1,2; last only on 0x3; 3 credits total.
- 7 VALID beats then DONE (MAX_BEATS=5) → 5 beats out, last on idx 4; err code 2 once; 2 dropped-beat credits plus 5 pop credits.
- out_ready=0, 9 single-beat packets → first 8 buffered; 9th raises err code 4 with no credit; then out_ready=1 drains 8 with 8 credits.
- DONE in IDLE, then type 3 → err codes 1 then 3; no output, no credits.
- rst_n low for 1 cycle mid-packet after 2 VALIDs → outputs 0 immediately; a fresh VALID+DONE is delivered normally with idx 0.
